// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard/stall controller.
// slave: the controller (samples ID/EX/MEM status, drives stall/flush/status).
interface pipeline_ctrl_if;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic        ID_rs1_used;
  logic        ID_rs2_used;
  logic [4:0]  EX_rd;
  logic        EX_is_load;
  logic        EX_br_taken;
  logic        MEM_req;
  logic        MEM_ack;
  logic        pc_stall;
  logic        dpc_control;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_hold;
  logic [1:0]  state;
  logic        timeout_err;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rd, EX_is_load,
           EX_br_taken, MEM_req, MEM_ack,
    output pc_stall, dpc_control, if_id_flush, id_ex_flush, ex_mem_hold,
           state, timeout_err, stall_cycles, flush_count
  );

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used, EX_rd, EX_is_load,
           EX_br_taken, MEM_req, MEM_ack,
    input  pc_stall, dpc_control, if_id_flush, id_ex_flush, ex_mem_hold,
           state, timeout_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: memory-wait holds, branch flushes,
// load-use bubbles, a start-up bubble, a wait timeout and perf counters.
module pipeline_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  pipeline_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_cnt_q;
  logic [7:0]  wait_cnt_d;
  logic        timeout_q;
  logic        timeout_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  logic        hazard;
  logic        resolve;
  logic        br_flush;
  logic        pc_stall;
  logic        dpc_control;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_hold;

  // EX_rd != 0 also guarantees a zero source index can never match.
  assign hazard = bus.EX_is_load && (bus.EX_rd != 5'd0) &&
                  ((bus.ID_rs1_used && (bus.ID_rs1 == bus.EX_rd)) ||
                   (bus.ID_rs2_used && (bus.ID_rs2 == bus.EX_rd)));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    resolve     = 1'b0;
    br_flush    = 1'b0;
    pc_stall    = 1'b0;
    dpc_control = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_hold = 1'b0;

    // While reset is held the outputs already look like BOOT.
    if (!rst_n) begin
      if_id_flush = 1'b1;
    end else begin
      case (state_q)
        BOOT: begin
          if_id_flush = 1'b1;
          state_d     = RUN;
        end
        RUN: begin
          if (bus.MEM_req && !bus.MEM_ack) begin
            pc_stall    = 1'b1;
            dpc_control = 1'b1;
            ex_mem_hold = 1'b1;
            state_d     = MEM_WAIT;
            wait_cnt_d  = 8'd1;
          end else begin
            resolve = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!bus.MEM_ack) begin
            pc_stall    = 1'b1;
            dpc_control = 1'b1;
            ex_mem_hold = 1'b1;
            wait_cnt_d  = wait_cnt_q + 8'd1;
            // Counter reaches 255 on this edge: give up and report.
            if (wait_cnt_q >= 8'd254) begin
              wait_cnt_d = 8'd255;
              timeout_d  = 1'b1;
              state_d    = RUN;
            end
          end else begin
            resolve = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase

      if (resolve) begin
        if (bus.EX_br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          br_flush    = 1'b1;
        end else if (hazard) begin
          pc_stall    = 1'b1;
          dpc_control = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      if (pc_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (br_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.dpc_control  = dpc_control;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_hold  = ex_mem_hold;
  assign bus.state        = state_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.stall_cycles = stall_cnt_q;
  assign bus.flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, load-use, branch priority,
// memory wait, timeout, reset out of MEM_WAIT and counter saturation.
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {pc_stall, dpc_control, if_id_flush, id_ex_flush, ex_mem_hold}.
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk(tag, {11'd0, bus.pc_stall, bus.dpc_control, bus.if_id_flush,
              bus.id_ex_flush, bus.ex_mem_hold}, {11'd0, exp});
  endtask

  task automatic idle_inputs();
    bus.ID_rs1      = 5'd0;
    bus.ID_rs2      = 5'd0;
    bus.ID_rs1_used = 1'b0;
    bus.ID_rs2_used = 1'b0;
    bus.EX_rd       = 5'd0;
    bus.EX_is_load  = 1'b0;
    bus.EX_br_taken = 1'b0;
    bus.MEM_req     = 1'b0;
    bus.MEM_ack     = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    // Reset held: BOOT outputs, state 0
    cyc();
    cyc();
    chk("rst_state", {14'd0, bus.state}, 16'd0);
    chk_ctrl("rst_ctrl", 5'b00100);

    // Release: cycle 0 in BOOT, cycle 1 in RUN
    rst_n = 1'b1;
    #1;
    chk("c0_state", {14'd0, bus.state}, 16'd0);
    chk_ctrl("c0_ctrl", 5'b00100);
    cyc();
    chk("c1_state", {14'd0, bus.state}, 16'd1);
    chk_ctrl("c1_ctrl", 5'b00000);
    chk("c1_stall", bus.stall_cycles, 16'd0);
    chk("c1_flush", bus.flush_count, 16'd0);
    chk("c1_tmo", {15'd0, bus.timeout_err}, 16'd0);

    // Load-use on rs2
    bus.EX_is_load = 1'b1; bus.EX_rd = 5'd5; bus.ID_rs2 = 5'd5; bus.ID_rs2_used = 1'b1;
    #1;
    chk_ctrl("lu_rs2_ctrl", 5'b11010);
    cyc();
    idle_inputs();
    #1;
    chk_ctrl("lu_after_ctrl", 5'b00000);
    chk("lu_stall", bus.stall_cycles, 16'd1);
    chk("lu_state", {14'd0, bus.state}, 16'd1);

    // EX_rd = 0 with rs2 = 0: no hazard
    bus.EX_is_load = 1'b1; bus.EX_rd = 5'd0; bus.ID_rs2 = 5'd0; bus.ID_rs2_used = 1'b1;
    #1;
    chk_ctrl("rd0_ctrl", 5'b00000);
    // Matching rs1 that is not used: no hazard
    bus.EX_rd = 5'd7; bus.ID_rs1 = 5'd7; bus.ID_rs1_used = 1'b0; bus.ID_rs2_used = 1'b0;
    #1;
    chk_ctrl("rs1_unused_ctrl", 5'b00000);
    // Same pair, rs1 used: hazard
    bus.ID_rs1_used = 1'b1;
    #1;
    chk_ctrl("lu_rs1_ctrl", 5'b11010);
    cyc();
    idle_inputs();
    #1;
    chk("lu_rs1_stall", bus.stall_cycles, 16'd2);

    // Branch beats load-use
    bus.EX_is_load = 1'b1; bus.EX_rd = 5'd9; bus.ID_rs1 = 5'd9; bus.ID_rs1_used = 1'b1;
    bus.EX_br_taken = 1'b1;
    #1;
    chk_ctrl("br_hz_ctrl", 5'b00110);
    cyc();
    idle_inputs();
    #1;
    chk("br_flush_cnt", bus.flush_count, 16'd1);
    chk("br_stall_cnt", bus.stall_cycles, 16'd2);

    // Memory wait for 4 cycles with branch held, then ack
    bus.MEM_req = 1'b1; bus.MEM_ack = 1'b0; bus.EX_br_taken = 1'b1;
    #1;
    chk_ctrl("mw0_ctrl", 5'b11001);
    for (int i = 1; i < 4; i++) begin
      cyc();
      chk("mw_state", {14'd0, bus.state}, 16'd2);
      chk_ctrl("mw_ctrl", 5'b11001);
    end
    cyc();
    bus.MEM_ack = 1'b1;
    #1;
    chk_ctrl("mw_ack_ctrl", 5'b00110);
    cyc();
    bus.MEM_req = 1'b0; bus.MEM_ack = 1'b0; bus.EX_br_taken = 1'b0;
    #1;
    chk("mw_done_state", {14'd0, bus.state}, 16'd1);
    chk("mw_stall_cnt", bus.stall_cycles, 16'd6);
    chk("mw_flush_cnt", bus.flush_count, 16'd2);

    // Request and ack together in RUN: no wait
    bus.MEM_req = 1'b1; bus.MEM_ack = 1'b1;
    #1;
    chk_ctrl("req_ack_ctrl", 5'b00000);
    cyc();
    chk("req_ack_state", {14'd0, bus.state}, 16'd1);

    // Timeout: 255 wait cycles with no ack
    bus.MEM_ack = 1'b0;
    repeat (254) cyc();
    chk("tmo_pre_state", {14'd0, bus.state}, 16'd2);
    chk("tmo_pre_err", {15'd0, bus.timeout_err}, 16'd0);
    cyc();
    chk("tmo_state", {14'd0, bus.state}, 16'd1);
    chk("tmo_err", {15'd0, bus.timeout_err}, 16'd1);
    chk("tmo_stall_cnt", bus.stall_cycles, 16'd261);
    cyc();
    chk("tmo_rewait_state", {14'd0, bus.state}, 16'd2);
    chk("tmo_sticky", {15'd0, bus.timeout_err}, 16'd1);
    cyc();

    // Reset from inside MEM_WAIT
    rst_n = 1'b0;
    #1;
    chk_ctrl("rst_mw_ctrl", 5'b00100);
    cyc();
    chk("rst_mw_state", {14'd0, bus.state}, 16'd0);
    chk("rst_mw_err", {15'd0, bus.timeout_err}, 16'd0);
    chk("rst_mw_stall", bus.stall_cycles, 16'd0);
    chk("rst_mw_flush", bus.flush_count, 16'd0);
    idle_inputs();
    rst_n = 1'b1;
    cyc();
    chk("rerun_state", {14'd0, bus.state}, 16'd1);

    // stall_cycles saturation under a persistent load-use hazard
    bus.EX_is_load = 1'b1; bus.EX_rd = 5'd3; bus.ID_rs2 = 5'd3; bus.ID_rs2_used = 1'b1;
    repeat (65534) cyc();
    chk("sat_fffe", bus.stall_cycles, 16'hFFFE);
    cyc();
    chk("sat_ffff", bus.stall_cycles, 16'hFFFF);
    repeat (3) cyc();
    chk("sat_hold", bus.stall_cycles, 16'hFFFF);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset; synchronous, active-low, sampled on rising clk edge.
REQ-003 SHALL provide: ID_rs1, ID_rs2  input  5 each  source register indices of the instruction in ID.
REQ-004 SHALL provide: ID_rs1_used, ID_rs2_used  input  1 each  corresponding source is actually read.
REQ-005 SHALL provide: EX_rd  input  5  destination index of the instruction in EX.
REQ-006 SHALL provide: EX_is_load  input  1  instruction in EX is a load.
REQ-007 SHALL provide: EX_br_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-008 SHALL provide: MEM_req, MEM_ack  input  1 each  data-memory access pending in MEM / access completes this cycle.
REQ-009 SHALL provide: pc_stall  output  1  hold PC.
REQ-010 SHALL provide: dpc_control  output  1  hold IF/ID register (pc and inst).
REQ-011 SHALL provide: if_id_flush, id_ex_flush  output  1 each  load bubble (NOP, pc 0) into IF/ID or ID/EX at next edge.
REQ-012 SHALL provide: ex_mem_hold  output  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-013 SHALL provide: state  output  2  current FSM state code; timeout_err  output  1  sticky.
REQ-014 SHALL provide: stall_cycles, flush_count  output  16 each  saturating performance counters.

Function
REQ-015 FSM states SHALL be BOOT=0, RUN=1, MEM_WAIT=2; code 3 unused, SHALL transition to BOOT.
REQ-016 Control outputs (REQ-009..012) SHALL be combinational from state and current inputs; state, wait counter, error and perf counters registered.
REQ-017 BOOT: if_id_flush=1, all other controls 0; next state RUN unconditionally (one start-up bubble).
REQ-018 RUN priority SHALL be: memory wait > branch flush > load-use stall > none.
REQ-019 RUN, MEM_req=1 and MEM_ack=0: pc_stall=dpc_control=ex_mem_hold=1, no flushes; next state MEM_WAIT, wait counter cleared to 1.
REQ-020 RUN, no memory wait, EX_br_taken=1: if_id_flush=id_ex_flush=1, no holds; flush_count +1.
REQ-021 Load-use hazard = EX_is_load and EX_rd!=0 and ((ID_rs1_used and ID_rs1==EX_rd) or (ID_rs2_used and ID_rs2==EX_rd)).
REQ-022 RUN, hazard, no memory wait, no branch: pc_stall=dpc_control=id_ex_flush=1, if_id_flush=0, ex_mem_hold=0; exactly one cycle, state stays RUN.
REQ-023 MEM_WAIT, MEM_ack=0: all three holds asserted, flushes 0, branch and hazard inputs ignored; wait counter +1.
REQ-024 MEM_WAIT, MEM_ack=1: holds deasserted that same cycle, REQ-020/022 evaluated normally, next state RUN.
REQ-025 RUN with MEM_req=1 and MEM_ack=1 same cycle SHALL be treated as no memory wait.
REQ-026 Wait counter 8 bits; reaching 255 in MEM_WAIT SHALL set timeout_err (sticky until reset) and force next state RUN.
REQ-027 stall_cycles SHALL increment on every cycle with pc_stall=1; both perf counters saturate at 0xFFFF, never wrap.
REQ-028 rs==0 SHALL never produce a hazard regardless of EX_rd.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state=BOOT, wait counter=0, timeout_err=0, stall_cycles=0, flush_count=0, from any state including MEM_WAIT.
REQ-030 While rst_n=0 and after, outputs SHALL follow state BOOT (if_id_flush=1, others 0) until the first edge with rst_n=1.
REQ-031 No asynchronous path from rst_n to any register.

Verification
REQ-032 Reset release -> cycle 0 state=0, if_id_flush=1; cycle 1 state=1, all controls 0, counters 0.
REQ-033 EX_is_load=1, EX_rd=5, ID_rs2=5, ID_rs2_used=1 for one cycle -> pc_stall=dpc_control=id_ex_flush=1 one cycle, stall_cycles=1; same with EX_rd=0 -> no stall.
REQ-034 EX_br_taken=1 together with load-use hazard -> if_id_flush=id_ex_flush=1, pc_stall=0, flush_count=1.
REQ-035 MEM_req=1, MEM_ack=0 for 4 cycles then MEM_ack=1, EX_br_taken=1 held throughout -> holds high 4 cycles, no flush until ack cycle, then both flushes, state back to 1, stall_cycles=4.
REQ-036 MEM_req=1, MEM_ack never -> timeout_err=1 after 255 wait cycles, state=1; rst_n=0 mid-MEM_WAIT -> next edge state=0, timeout_err=0.
